// File: rtl/sequence_generator.sv
// Transmits the 11,01,10 symbol sequence a programmable number of times with
// idle 00 gaps between repetitions, then pulses done for one cycle.
module sequence_generator #(
  parameter int REPS_W = 4,
  parameter int GAP    = 1
) (
  input  logic              clock,
  input  logic              reset_,
  input  logic              start,
  input  logic [REPS_W-1:0] reps,
  output logic [1:0]        x1_x0,
  output logic              valid,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_S11  = 3'd1,
    ST_S01  = 3'd2,
    ST_S10  = 3'd3,
    ST_GAP  = 3'd4,
    ST_DONE = 3'd5
  } state_t;

  localparam logic [3:0] GAP_LOAD = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  state_t            state_q, state_d;
  logic [REPS_W-1:0] rem_q, rem_d;
  logic [3:0]        gap_q, gap_d;
  logic [1:0]        x1_x0_q, x1_x0_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  // Next-state, counter update and start acceptance.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    gap_d   = gap_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          rem_d = reps;
          if (reps != {REPS_W{1'b0}}) begin
            state_d = ST_S11;
          end else begin
            state_d = ST_DONE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_S11: state_d = ST_S01;
      ST_S01: state_d = ST_S10;
      ST_S10: begin
        // rem is at least 1 here, so the decrement never wraps
        rem_d = rem_q - REPS_W'(1);
        if (rem_d == {REPS_W{1'b0}}) begin
          state_d = ST_DONE;
        end else if (GAP > 0) begin
          state_d = ST_GAP;
          gap_d   = GAP_LOAD;
        end else begin
          state_d = ST_S11;
        end
      end
      ST_GAP: begin
        if (gap_q == 4'd0) begin
          state_d = ST_S11;
        end else begin
          gap_d = gap_q - 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        rem_d   = {REPS_W{1'b0}};
        gap_d   = 4'd0;
      end
    endcase
  end

  // Outputs decoded from the next state so they appear registered, aligned with state_q.
  always_comb begin
    x1_x0_d = 2'b00;
    valid_d = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state_d)
      ST_S11: begin
        x1_x0_d = 2'b11;
        valid_d = 1'b1;
        busy_d  = 1'b1;
      end
      ST_S01: begin
        x1_x0_d = 2'b01;
        valid_d = 1'b1;
        busy_d  = 1'b1;
      end
      ST_S10: begin
        x1_x0_d = 2'b10;
        valid_d = 1'b1;
        busy_d  = 1'b1;
      end
      ST_GAP:  busy_d = 1'b1;
      ST_DONE: done_d = 1'b1;
      default: begin
        x1_x0_d = 2'b00;
        valid_d = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  // State, counters and output registers with asynchronous active-low reset.
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      state_q <= ST_IDLE;
      rem_q   <= {REPS_W{1'b0}};
      gap_q   <= 4'd0;
      x1_x0_q <= 2'b00;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      gap_q   <= gap_d;
      x1_x0_q <= x1_x0_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign x1_x0 = x1_x0_q;
  assign valid = valid_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_sequence_generator.sv
// Directed-vector bench for sequence_generator with default parameters
// (REPS_W=4, GAP=1); expected outputs are written out by hand.
module tb_sequence_generator;

  logic       clock;
  logic       reset_;
  logic       start;
  logic [3:0] reps;
  logic [1:0] x1_x0;
  logic       valid;
  logic       busy;
  logic       done;

  int cmp_cnt;
  int fail_cnt;

  sequence_generator dut (
    .clock (clock),
    .reset_(reset_),
    .start (start),
    .reps  (reps),
    .x1_x0 (x1_x0),
    .valid (valid),
    .busy  (busy),
    .done  (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // expected outputs packed as {x1_x0, valid, busy, done}
  typedef struct {
    logic       start;
    logic [3:0] reps;
    logic [4:0] exp;
  } vec_t;

  vec_t vecs[$];

  localparam logic [4:0] O_IDLE = 5'b00_0_0_0;
  localparam logic [4:0] O_S11  = 5'b11_1_1_0;
  localparam logic [4:0] O_S01  = 5'b01_1_1_0;
  localparam logic [4:0] O_S10  = 5'b10_1_1_0;
  localparam logic [4:0] O_GAP  = 5'b00_0_1_0;
  localparam logic [4:0] O_DONE = 5'b00_0_0_1;

  task automatic check(input string name, input logic [4:0] exp);
    logic [4:0] got;
    got = {x1_x0, valid, busy, done};
    cmp_cnt++;
    if (got !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got x1_x0/valid/busy/done=%b required %b at %0t", name, got, exp, $time);
    end
  endtask

  task automatic step(input logic s, input logic [3:0] r);
    @(negedge clock);
    start = s;
    reps  = r;
    @(posedge clock);
    #1;
  endtask

  task automatic add(input logic s, input logic [3:0] r, input logic [4:0] e);
    vec_t v;
    v.start = s;
    v.reps  = r;
    v.exp   = e;
    vecs.push_back(v);
  endtask

  initial begin
    int n10;
    int nbusy;
    int nvalid;
    bit seen_done;
    cmp_cnt  = 0;
    fail_cnt = 0;
    start    = 1'b0;
    reps     = 4'd0;
    reset_   = 1'b0;

    // single run, reps=1
    add(1'b1, 4'd1, O_S11);
    add(1'b0, 4'd0, O_S01);
    add(1'b0, 4'd0, O_S10);
    add(1'b0, 4'd0, O_DONE);
    add(1'b0, 4'd0, O_IDLE);
    // reps=3 with one-cycle gaps
    add(1'b1, 4'd3, O_S11);
    add(1'b0, 4'd0, O_S01);
    add(1'b0, 4'd0, O_S10);
    add(1'b0, 4'd0, O_GAP);
    add(1'b0, 4'd0, O_S11);
    add(1'b0, 4'd0, O_S01);
    add(1'b0, 4'd0, O_S10);
    add(1'b0, 4'd0, O_GAP);
    add(1'b0, 4'd0, O_S11);
    add(1'b0, 4'd0, O_S01);
    add(1'b0, 4'd0, O_S10);
    add(1'b0, 4'd0, O_DONE);
    add(1'b0, 4'd0, O_IDLE);
    // reps=0: immediate done
    add(1'b1, 4'd0, O_DONE);
    add(1'b0, 4'd0, O_IDLE);
    // reps=2 with ignored start(reps=5) mid-run, then back-to-back reps=1
    add(1'b1, 4'd2, O_S11);
    add(1'b1, 4'd5, O_S01);
    add(1'b1, 4'd5, O_S10);
    add(1'b1, 4'd5, O_GAP);
    add(1'b0, 4'd0, O_S11);
    add(1'b0, 4'd0, O_S01);
    add(1'b0, 4'd0, O_S10);
    add(1'b0, 4'd0, O_DONE);
    add(1'b0, 4'd0, O_IDLE);
    add(1'b1, 4'd2, O_S11);
    add(1'b0, 4'd0, O_S01);
    add(1'b0, 4'd0, O_S10);
    add(1'b0, 4'd0, O_GAP);
    add(1'b0, 4'd0, O_S11);
    add(1'b0, 4'd0, O_S01);
    add(1'b0, 4'd0, O_S10);
    add(1'b1, 4'd1, O_DONE);
    add(1'b1, 4'd1, O_S11);
    add(1'b0, 4'd0, O_S01);
    add(1'b0, 4'd0, O_S10);
    add(1'b0, 4'd0, O_DONE);
    add(1'b0, 4'd0, O_IDLE);

    #3;
    check("reset_state", O_IDLE);
    @(negedge clock);
    reset_ = 1'b1;
    step(1'b0, 4'd0);
    check("post_reset_idle", O_IDLE);
    step(1'b0, 4'd0);
    check("post_reset_idle2", O_IDLE);

    foreach (vecs[i]) begin
      step(vecs[i].start, vecs[i].reps);
      check($sformatf("vec%0d", i), vecs[i].exp);
    end

    // maximum reps: 15 repetitions, 3*15+14 busy cycles, no wrap of rem
    step(1'b1, 4'd15);
    check("max_first", O_S11);
    n10 = 0;
    nbusy = 0;
    nvalid = 0;
    seen_done = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (done) begin
        seen_done = 1'b1;
        break;
      end
      if (busy) nbusy++;
      if (valid) nvalid++;
      if (x1_x0 == 2'b10 && valid) n10++;
      step(1'b0, 4'd0);
    end
    cmp_cnt++;
    if (!seen_done) begin
      fail_cnt++;
      $display("FAIL max_done_timeout: done not seen within 100 cycles, required a done pulse");
    end
    cmp_cnt++;
    if (n10 != 15) begin
      fail_cnt++;
      $display("FAIL max_reps: got %0d repetitions required 15", n10);
    end
    cmp_cnt++;
    if (nbusy != 59) begin
      fail_cnt++;
      $display("FAIL max_busy: got %0d busy cycles required 59", nbusy);
    end
    cmp_cnt++;
    if (nvalid != 45) begin
      fail_cnt++;
      $display("FAIL max_valid: got %0d valid cycles required 45", nvalid);
    end
    step(1'b0, 4'd0);
    check("max_idle", O_IDLE);

    // abort in S01 of a reps=4 run via asynchronous reset
    step(1'b1, 4'd4);
    check("abort_s11", O_S11);
    step(1'b0, 4'd0);
    check("abort_s01", O_S01);
    #2;
    reset_ = 1'b0;
    #1;
    check("abort_async", O_IDLE);
    seen_done = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clock);
      #1;
      if (done) seen_done = 1'b1;
    end
    @(negedge clock);
    reset_ = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step(1'b0, 4'd0);
      if (done) seen_done = 1'b1;
    end
    cmp_cnt++;
    if (seen_done) begin
      fail_cnt++;
      $display("FAIL abort_no_done: got done pulse after abort required none");
    end
    check("abort_idle", O_IDLE);
    step(1'b1, 4'd1);
    check("restart_s11", O_S11);
    step(1'b0, 4'd0);
    check("restart_s01", O_S01);
    step(1'b0, 4'd0);
    check("restart_s10", O_S10);
    step(1'b0, 4'd0);
    check("restart_done", O_DONE);
    step(1'b0, 4'd0);
    check("restart_idle", O_IDLE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
    $finish;
  end

endmodule
